// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data memory
//
// Purpose: shares one single-ported memory between the fetch stage (IF) and the
// data-memory stage (DM). One access is in flight at a time. Each access goes
// IDLE -> ISSUE (strobe + grant) and, for reads, WAIT for MEM_LAT cycles before the
// read data is captured and returned with a one-cycle rvalid pulse in the next IDLE.
// DM has priority; IF is forced through after STARVE_MAX consecutive DM wins while
// IF is waiting.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   if_req/if_addr                   fetch request and address (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        fetch grant pulse, read-valid pulse, read data
//   dm_req/dm_we/dm_addr/dm_wdata    data request, write flag, address, write data
//   dm_gnt/dm_rvalid/dm_rdata        data grant pulse, read-valid pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe, write enable, address, write data
//   mem_rdata                        memory read data, valid MEM_LAT cycles after mem_en
//   mem_src                          owner code for the hazard unit (00 idle/fetch,
//                                    01 data read in flight, 10 data write in flight)

`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_src
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Owner encoding doubles as the mem_src code while a data access is in flight.
    typedef enum logic [1:0] {
        OWN_IF = 2'b00,
        OWN_DR = 2'b01,
        OWN_DW = 2'b10
    } owner_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [3:0] LAT        = 4'(MEM_LAT);

    state_t            state_q;
    owner_t            owner_q;
    logic [2:0]        starve_q;
    logic [2:0]        starve_d;
    logic [3:0]        wait_q;
    logic              pick_if;
    logic              pick_dm;

    logic              if_gnt_q;
    logic              if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              dm_gnt_q;
    logic              dm_rvalid_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        mem_src_q;

    // Winner selection, only acted upon in IDLE. A pending fetch that has watched
    // STARVE_MAX data wins in a row takes the port regardless of dm_req.
    always_comb begin
        pick_if  = if_req && (!dm_req || (starve_q == STARVE_LIM));
        pick_dm  = dm_req && !pick_if;
        starve_d = starve_q;
        if (pick_if) begin
            starve_d = 3'd0;
        end else if (pick_dm) begin
            starve_d = if_req ? (starve_q + 3'd1) : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= 3'd0;
            wait_q      <= 4'd0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_gnt_q    <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_src_q   <= 2'b00;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle below.
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_if || pick_dm) begin
                        state_q  <= ST_ISSUE;
                        starve_q <= starve_d;
                        mem_en_q <= 1'b1;
                        if (pick_if) begin
                            owner_q    <= OWN_IF;
                            mem_addr_q <= if_addr;
                            mem_we_q   <= 1'b0;
                            if_gnt_q   <= 1'b1;
                            mem_src_q  <= 2'b00;
                        end else begin
                            owner_q     <= dm_we ? OWN_DW : OWN_DR;
                            mem_addr_q  <= dm_addr;
                            mem_we_q    <= dm_we;
                            mem_wdata_q <= dm_wdata;
                            dm_gnt_q    <= 1'b1;
                            mem_src_q   <= dm_we ? 2'b10 : 2'b01;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (owner_q == OWN_DW) begin
                        // Writes finish in the issue cycle; no read data to wait for.
                        state_q   <= ST_IDLE;
                        mem_src_q <= 2'b00;
                    end else begin
                        state_q <= ST_WAIT;
                        wait_q  <= LAT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    // wait_q reaches 1 in the cycle mem_rdata is valid.
                    if (wait_q == 4'd1) begin
                        state_q   <= ST_IDLE;
                        mem_src_q <= 2'b00;
                        if (owner_q == OWN_IF) begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end else begin
                            dm_rdata_q  <= mem_rdata;
                            dm_rvalid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_gnt    = dm_gnt_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_src   = mem_src_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter

`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int SM     = 3;
    localparam int NI     = 2;
    localparam int NCYC   = 3000;

    // Instance 0 runs with MEM_LAT=2, instance 1 with the MEM_LAT=1 boundary.
    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          dm_req    [NI];
    logic          dm_we     [NI];
    logic [AW-1:0] dm_addr   [NI];
    logic [DW-1:0] dm_wdata  [NI];
    logic          dm_gnt    [NI];
    logic          dm_rvalid [NI];
    logic [DW-1:0] dm_rdata  [NI];
    logic          mem_en    [NI];
    logic          mem_we    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic [DW-1:0] mem_rdata [NI];
    logic [1:0]    mem_src   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .MEM_LAT   ((g == 0) ? 2 : 1),
            .STARVE_MAX(SM)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .dm_req   (dm_req[g]),
            .dm_we    (dm_we[g]),
            .dm_addr  (dm_addr[g]),
            .dm_wdata (dm_wdata[g]),
            .dm_gnt   (dm_gnt[g]),
            .dm_rvalid(dm_rvalid[g]),
            .dm_rdata (dm_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_src  (mem_src[g])
        );
    end

    // Transaction-level reference: one record per instance for the latest access,
    // plus per-requester expected read-return cycle and held read data.
    int            n_vec;
    int            n_err;
    int            free_at [NI];
    int            starve  [NI];
    bit            tr_act  [NI];
    int            tr_t    [NI];
    int            tr_kind [NI];   // 0 fetch, 1 data read, 2 data write
    logic [AW-1:0] tr_addr [NI];
    logic [DW-1:0] tr_wdata[NI];
    int            rv_at   [NI][2];
    logic [DW-1:0] pend    [NI][2];
    logic [DW-1:0] exp_rd  [NI][2];
    int            ret_at  [NI];
    logic [DW-1:0] ret_val [NI];
    bit            zero_chk[NI];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  lat;
        int  rst_left;
        int  r;
        bit  ge;
        bit  if_win;
        logic [1:0] exp_src;
        string pfx;

        n_vec    = 0;
        n_err    = 0;
        rst_left = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < NI; k++) begin
            if_req[k]    = 1'b0;
            if_addr[k]   = '0;
            dm_req[k]    = 1'b0;
            dm_we[k]     = 1'b0;
            dm_addr[k]   = '0;
            dm_wdata[k]  = '0;
            mem_rdata[k] = '0;
            free_at[k]   = 0;
            starve[k]    = 0;
            tr_act[k]    = 1'b0;
            tr_t[k]      = 0;
            tr_kind[k]   = 0;
            tr_addr[k]   = '0;
            tr_wdata[k]  = '0;
            ret_at[k]    = -1;
            ret_val[k]   = '0;
            zero_chk[k]  = 1'b0;
            for (int q = 0; q < 2; q++) begin
                rv_at[k][q]  = -1;
                pend[k][q]   = '0;
                exp_rd[k][q] = '0;
            end
        end

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);

            // Reset for the opening cycles (with both requests up), then rare pulses.
            if (c < 3) begin
                rst_n = 1'b0;
            end else if (rst_left > 0) begin
                rst_n    = 1'b0;
                rst_left = rst_left - 1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n    = 1'b0;
                rst_left = $urandom_range(0, 1);
            end else begin
                rst_n = 1'b1;
            end

            for (int k = 0; k < NI; k++) begin
                lat = lat_of(k);
                pfx = $sformatf("u%0d c%0d", k, c);

                for (int q = 0; q < 2; q++) begin
                    if (rv_at[k][q] == c) exp_rd[k][q] = pend[k][q];
                end

                if (c > 0) begin
                    ge = tr_act[k] && (c == tr_t[k] + 1);
                    exp_src = 2'b00;
                    if (tr_act[k] && tr_kind[k] == 1 && c >= tr_t[k] + 1 && c <= tr_t[k] + 1 + lat)
                        exp_src = 2'b01;
                    if (tr_act[k] && tr_kind[k] == 2 && c == tr_t[k] + 1)
                        exp_src = 2'b10;
                    check_eq({pfx, " if_gnt"},    32'(if_gnt[k]),    32'(ge && tr_kind[k] == 0));
                    check_eq({pfx, " dm_gnt"},    32'(dm_gnt[k]),    32'(ge && tr_kind[k] != 0));
                    check_eq({pfx, " mem_en"},    32'(mem_en[k]),    32'(ge));
                    check_eq({pfx, " mem_src"},   32'(mem_src[k]),   32'(exp_src));
                    check_eq({pfx, " if_rvalid"}, 32'(if_rvalid[k]), 32'(rv_at[k][0] == c));
                    check_eq({pfx, " dm_rvalid"}, 32'(dm_rvalid[k]), 32'(rv_at[k][1] == c));
                    check_eq({pfx, " if_rdata"},  32'(if_rdata[k]),  32'(exp_rd[k][0]));
                    check_eq({pfx, " dm_rdata"},  32'(dm_rdata[k]),  32'(exp_rd[k][1]));
                    if (ge) begin
                        check_eq({pfx, " mem_addr"}, 32'(mem_addr[k]), 32'(tr_addr[k]));
                        check_eq({pfx, " mem_we"},   32'(mem_we[k]),   32'(tr_kind[k] == 2));
                        if (tr_kind[k] == 2)
                            check_eq({pfx, " mem_wdata"}, 32'(mem_wdata[k]), 32'(tr_wdata[k]));
                    end
                    if (zero_chk[k]) begin
                        check_eq({pfx, " rst mem_addr"},  32'(mem_addr[k]),  32'd0);
                        check_eq({pfx, " rst mem_we"},    32'(mem_we[k]),    32'd0);
                        check_eq({pfx, " rst mem_wdata"}, 32'(mem_wdata[k]), 32'd0);
                        zero_chk[k] = 1'b0;
                    end
                end

                // Requester agents: drop in the grant cycle, otherwise raise/abandon randomly.
                if (c == 0) begin
                    if_req[k]   = 1'b1;
                    if_addr[k]  = AW'($urandom);
                    dm_req[k]   = 1'b1;
                    dm_we[k]    = 1'($urandom_range(0, 1));
                    dm_addr[k]  = AW'($urandom);
                    dm_wdata[k] = DW'($urandom);
                end else if (c >= 3) begin
                    if (tr_act[k] && c == tr_t[k] + 1 && tr_kind[k] == 0) begin
                        if_req[k] = 1'b0;
                    end else if (!if_req[k]) begin
                        if ($urandom_range(0, 3) != 0) begin
                            if_req[k]  = 1'b1;
                            if_addr[k] = AW'($urandom);
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        if_req[k] = 1'b0;
                    end
                    if (tr_act[k] && c == tr_t[k] + 1 && tr_kind[k] != 0) begin
                        dm_req[k] = 1'b0;
                    end else if (!dm_req[k]) begin
                        if ($urandom_range(0, 3) != 0) begin
                            dm_req[k]   = 1'b1;
                            dm_we[k]    = 1'($urandom_range(0, 2) == 0);
                            dm_addr[k]  = AW'($urandom);
                            dm_wdata[k] = DW'($urandom);
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        dm_req[k] = 1'b0;
                    end
                end

                // Memory: real data only in the return cycle, noise otherwise.
                mem_rdata[k] = (ret_at[k] == c) ? ret_val[k] : DW'($urandom);

                // Reference arbitration on the values sampled at the end of this cycle.
                if (!rst_n) begin
                    tr_act[k]   = 1'b0;
                    starve[k]   = 0;
                    free_at[k]  = c + 1;
                    zero_chk[k] = 1'b1;
                    for (int q = 0; q < 2; q++) begin
                        rv_at[k][q]  = -1;
                        exp_rd[k][q] = '0;
                    end
                end else if (c >= free_at[k] && (if_req[k] || dm_req[k])) begin
                    if_win = if_req[k] && (!dm_req[k] || starve[k] == SM);
                    if (if_win)         starve[k] = 0;
                    else if (if_req[k]) starve[k] = starve[k] + 1;
                    else                starve[k] = 0;
                    tr_act[k]   = 1'b1;
                    tr_t[k]     = c;
                    tr_kind[k]  = if_win ? 0 : (dm_we[k] ? 2 : 1);
                    tr_addr[k]  = if_win ? if_addr[k] : dm_addr[k];
                    tr_wdata[k] = dm_wdata[k];
                    if (tr_kind[k] == 2) begin
                        free_at[k] = c + 2;
                    end else begin
                        r           = (tr_kind[k] == 0) ? 0 : 1;
                        free_at[k]  = c + 2 + lat;
                        rv_at[k][r] = c + 2 + lat;
                        pend[k][r]  = DW'($urandom);
                        ret_at[k]   = c + 1 + lat;
                        ret_val[k]  = pend[k][r];
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
